dmem_responder: RTL and testbench

- Data-memory target that the processor's MEM-stage load/store initiator talks to over a valid/ready request channel and a valid/ready response channel.
- Replaces the fixed-latency synchronous data RAM with a responder that buffers requests, serves them in order after a programmable access latency, and flags misaligned accesses.
- Sits between the processor's MEM stage and a 4K-word RAM that is internal to the block.

---
 rtl/dmem_responder_if.sv | 32 +++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response channel between the MEM-stage load/store initiator and
// the data-memory responder.
//   Request  : w_req_vld, r_req_rdy, w_req_we, w_req_addr[31:0], w_req_wdata[31:0]
//   Response : r_rsp_vld, w_rsp_rdy, r_rsp_rdata[31:0], r_rsp_we, r_rsp_err
//   Status   : r_busy
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        w_req_vld;
  logic        r_req_rdy;
  logic        w_req_we;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        r_rsp_vld;
  logic        w_rsp_rdy;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_we;
  logic        r_rsp_err;
  logic        r_busy;

  modport master (
    output w_req_vld, w_req_we, w_req_addr, w_req_wdata, w_rsp_rdy,
    input  r_req_rdy, r_rsp_vld, r_rsp_rdata, r_rsp_we, r_rsp_err, r_busy
  );

  modport slave (
    input  w_req_vld, w_req_we, w_req_addr, w_req_wdata, w_rsp_rdy,
    output r_req_rdy, r_rsp_vld, r_rsp_rdata, r_rsp_we, r_rsp_err, r_busy
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the MEM stage. Requests are buffered in a 2-entry
// FIFO and served strictly in order by an IDLE/WAIT/RESP engine that spends
// LATENCY cycles in WAIT before touching the internal 2**AW x 32 RAM.
// Misaligned byte addresses are answered with err=1 and never write the RAM.
// Ports:
//   w_clk   : clock, rising edge
//   w_rst_n : asynchronous active-low reset (RAM contents are kept)
//   bus     : dmem_responder_if.slave (request/response channels, r_busy)
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  dmem_responder_if.slave   bus
);

  localparam int         DEPTH  = 1 << AW;
  localparam int         SAW    = AW + 2;      // byte-address bits actually decoded
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;

  // Request FIFO; upper address bits are dropped here, which gives the aliasing.
  logic              r_fifo_we    [2];
  logic [SAW-1:0]    r_fifo_addr  [2];
  logic [31:0]       r_fifo_wdata [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  // Working register holding the request currently being served.
  logic              r_wk_we;
  logic [SAW-1:0]    r_wk_addr;
  logic [31:0]       r_wk_wdata;

  logic [31:0]       r_mem [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count_nxt;
  logic              w_head_we;
  logic [SAW-1:0]    w_head_addr;
  logic [31:0]       w_head_wdata;
  logic [AW-1:0]     w_wk_idx;
  logic              w_wk_aligned;
  logic              w_mem_we;

  function automatic logic is_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

  // FIFO handshake, pop decision and RAM write strobe.
  always_comb begin
    w_push       = bus.w_req_vld && bus.r_req_rdy;
    // Pop either from IDLE or straight out of RESP on the response handshake.
    if (r_count != 2'd0) begin
      w_pop = (r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.w_rsp_rdy);
    end else begin
      w_pop = 1'b0;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
    w_head_we    = r_fifo_we[r_rd_ptr];
    w_head_addr  = r_fifo_addr[r_rd_ptr];
    w_head_wdata = r_fifo_wdata[r_rd_ptr];
    w_wk_idx     = r_wk_addr[SAW-1:2];
    w_wk_aligned = is_aligned(r_wk_addr[1:0]);
    w_mem_we     = (r_state == ST_WAIT) && (r_cnt == 4'd0) && r_wk_we && w_wk_aligned;
  end

  // Request FIFO storage, pointers, count and registered ready.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_count       <= 2'd0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      bus.r_req_rdy <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_fifo_we[i]    <= 1'b0;
        r_fifo_addr[i]  <= '0;
        r_fifo_wdata[i] <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_fifo_we[r_wr_ptr]    <= bus.w_req_we;
        r_fifo_addr[r_wr_ptr]  <= bus.w_req_addr[SAW-1:0];
        r_fifo_wdata[r_wr_ptr] <= bus.w_req_wdata;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count       <= w_count_nxt;
      // Ready follows the count seen at the start of the next cycle only.
      bus.r_req_rdy <= (w_count_nxt < 2'd2);
    end
  end

  // RAM write port; no reset so contents survive w_rst_n.
  always_ff @(posedge w_clk) begin
    if (w_mem_we) begin
      r_mem[w_wk_idx] <= r_wk_wdata;
    end
  end

  // Serving FSM with registered response and busy outputs.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 4'd0;
      r_wk_we         <= 1'b0;
      r_wk_addr       <= '0;
      r_wk_wdata      <= 32'd0;
      bus.r_rsp_vld   <= 1'b0;
      bus.r_rsp_rdata <= 32'd0;
      bus.r_rsp_we    <= 1'b0;
      bus.r_rsp_err   <= 1'b0;
      bus.r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_wk_we    <= w_head_we;
            r_wk_addr  <= w_head_addr;
            r_wk_wdata <= w_head_wdata;
            r_cnt      <= LAT_M1;
            r_state    <= ST_WAIT;
            bus.r_busy <= 1'b1;
          end else begin
            bus.r_busy <= (w_count_nxt != 2'd0);
          end
        end
        ST_WAIT: begin
          bus.r_busy <= 1'b1;
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            bus.r_rsp_vld   <= 1'b1;
            bus.r_rsp_we    <= r_wk_we;
            bus.r_rsp_err   <= !w_wk_aligned;
            bus.r_rsp_rdata <= (w_wk_aligned && !r_wk_we) ? r_mem[w_wk_idx] : 32'd0;
            r_state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.w_rsp_rdy) begin
            bus.r_rsp_vld <= 1'b0;
            if (w_pop) begin
              // Back-to-back: no IDLE bubble between requests.
              r_wk_we    <= w_head_we;
              r_wk_addr  <= w_head_addr;
              r_wk_wdata <= w_head_wdata;
              r_cnt      <= LAT_M1;
              r_state    <= ST_WAIT;
              bus.r_busy <= 1'b1;
            end else begin
              r_state    <= ST_IDLE;
              bus.r_busy <= (w_count_nxt != 2'd0);
            end
          end else begin
            bus.r_busy <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          bus.r_rsp_vld <= 1'b0;
          bus.r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (AW=12, LATENCY=2). A negedge
// monitor records accepted requests in a queue and, on each response
// handshake, derives the expected response from a word-indexed memory model
// that applies requests in order.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if u_if ();

  dmem_responder #(.AW(12), .LATENCY(2)) u_dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .bus     (u_if)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  req_t        req_q[$];
  int          rsp_cyc[$];
  logic [31:0] model_mem [int];
  logic        rnd_on = 1'b0;

  // Free-running cycle counter for timing checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: score responses against the model, then record newly accepted requests.
  always @(negedge clk) begin : mon
    req_t        r;
    logic [31:0] e_rd;
    logic        e_err;
    int          idx;
    if (rst_n && u_if.r_rsp_vld && u_if.w_rsp_rdy) begin
      rsp_cyc.push_back(cyc);
      if (req_q.size() == 0) begin
        chk("rsp_without_req", 32'(req_q.size()), 32'd1);
      end else begin
        r     = req_q.pop_front();
        idx   = int'((r.addr / 32'd4) % 32'd4096);
        e_err = (r.addr % 32'd4) != 32'd0;
        if (e_err) begin
          e_rd = 32'd0;
        end else if (r.we) begin
          e_rd = 32'd0;
          model_mem[idx] = r.wdata;
        end else begin
          e_rd = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
        end
        chk("rsp_rdata", u_if.r_rsp_rdata, e_rd);
        chk("rsp_we",    {31'd0, u_if.r_rsp_we},  {31'd0, r.we});
        chk("rsp_err",   {31'd0, u_if.r_rsp_err}, {31'd0, e_err});
      end
    end
    if (rst_n && u_if.w_req_vld && u_if.r_req_rdy) begin
      r.we    = u_if.w_req_we;
      r.addr  = u_if.w_req_addr;
      r.wdata = u_if.w_req_wdata;
      req_q.push_back(r);
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d);
    int   n    = 0;
    logic done = 1'b0;
    u_if.w_req_vld   = 1'b1;
    u_if.w_req_we    = we;
    u_if.w_req_addr  = a;
    u_if.w_req_wdata = d;
    while (!done && n < 100) begin
      @(negedge clk);
      done = u_if.r_req_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    chk("req_accepted", {31'd0, done}, 32'd1);
    u_if.w_req_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int   n    = 0;
    logic done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk);
      done = !u_if.r_busy && !u_if.r_rsp_vld && (req_q.size() == 0);
      n++;
    end
    chk("drain", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int e[4];
    u_if.w_req_vld   = 1'b0;
    u_if.w_req_we    = 1'b0;
    u_if.w_req_addr  = 32'd0;
    u_if.w_req_wdata = 32'd0;
    u_if.w_rsp_rdy   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_vld",   {31'd0, u_if.r_rsp_vld}, 32'd0);
    chk("rst_rsp_rdata", u_if.r_rsp_rdata,        32'd0);
    chk("rst_rsp_we",    {31'd0, u_if.r_rsp_we},  32'd0);
    chk("rst_rsp_err",   {31'd0, u_if.r_rsp_err}, 32'd0);
    chk("rst_busy",      {31'd0, u_if.r_busy},    32'd0);
    chk("rst_req_rdy",   {31'd0, u_if.r_req_rdy}, 32'd1);
    @(posedge clk);
    #1;

    // Give every word the bench will ever load a known value.
    for (int w = 0; w < 16; w++) do_req(1'b1, 32'(w * 4), $urandom);
    wait_idle();

    // Store then load, with load latency measured from acceptance.
    do_req(1'b1, 32'h10, 32'h12345678);
    wait_idle();
    do_req(1'b0, 32'h10, 32'd0);
    n = 0;
    while (!u_if.r_rsp_vld && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("load_latency", 32'(n), 32'd3);
    wait_idle();

    // Four back-to-back loads with the request valid held high.
    rsp_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("rdy_low_when_full", {31'd0, u_if.r_req_rdy}, 32'd0);
      do_req(1'b0, 32'(32'h20 + i * 4), 32'd0);
      e[i] = cyc;
    end
    wait_idle();
    chk("b2b_acc_gap01", 32'(e[1] - e[0]), 32'd1);
    chk("b2b_acc_gap12", 32'(e[2] - e[1]), 32'd1);
    chk("b2b_acc_gap23", 32'(e[3] - e[2]), 32'd3);
    chk("b2b_rsp_count", 32'(rsp_cyc.size()), 32'd4);
    for (int i = 1; i < rsp_cyc.size(); i++) chk("b2b_rsp_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);

    // Response held for 10 cycles while a store to the same word waits.
    do_req(1'b1, 32'h8, 32'hCAFEF00D);
    wait_idle();
    u_if.w_rsp_rdy = 1'b0;
    do_req(1'b0, 32'h8, 32'd0);
    do_req(1'b1, 32'h8, 32'h11111111);
    n = 0;
    while (!u_if.r_rsp_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_vld_seen", {31'd0, u_if.r_rsp_vld}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_vld",   {31'd0, u_if.r_rsp_vld}, 32'd1);
      chk("stall_rdata", u_if.r_rsp_rdata,        32'hCAFEF00D);
    end
    @(posedge clk);
    #1;
    u_if.w_rsp_rdy = 1'b1;
    wait_idle();
    do_req(1'b0, 32'h8, 32'd0);
    wait_idle();

    // Misaligned store must not disturb the aligned word.
    do_req(1'b1, 32'h13, 32'hFFFFFFFF);
    do_req(1'b0, 32'h10, 32'd0);
    wait_idle();

    // Reset during WAIT of a store discards it.
    do_req(1'b1, 32'h20, 32'h00000005);
    wait_idle();
    do_req(1'b1, 32'h20, 32'hDEAD0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", {31'd0, u_if.r_rsp_vld}, 32'd0);
    chk("midrst_busy",    {31'd0, u_if.r_busy},    32'd0);
    req_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_req_rdy", {31'd0, u_if.r_req_rdy}, 32'd1);
    do_req(1'b0, 32'h20, 32'd0);
    wait_idle();

    // Upper address bits alias.
    do_req(1'b1, 32'h4004, 32'hA5A5A5A5);
    do_req(1'b0, 32'h0004, 32'd0);
    wait_idle();

    // Random mix with random response back-pressure.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          u_if.w_rsp_rdy = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      logic [31:0] lo;
      lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      a  = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 15)) << 2) | lo;
      do_req(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    u_if.w_rsp_rdy = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
